// File: rtl/prog_loader.sv
// prog_loader
//
// Boot-time program loader sitting upstream of the pipelined CPU. It takes a
// little-endian byte stream from a host link, assembles 32-bit instruction
// words and writes them into instruction memory from word address 0. The CPU
// is held in reset until the whole image has landed.
//
// Image format: 4-byte word count N (LSB first), then N words of 4 bytes each
// (LSB first). With LOADER_CHECKSUM_EN defined, one trailing byte follows that
// must equal the XOR of every header and data byte.
//
// Ports:
//   clk         single clock, shared with the CPU
//   rst         asynchronous active-low reset
//   start       one-cycle pulse; begins a load from IDLE, DONE or ERR
//   rx_data     incoming byte
//   rx_valid    rx_data is valid
//   rx_ready    loader accepts a byte (transfer on rx_valid && rx_ready)
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   word address of the current write
//   imem_wdata  assembled instruction word
//   cpu_rst     active-high CPU reset, low only in DONE
//   load_done   image fully written, CPU running
//   load_err    sticky error flag, cleared by start or rst
//   word_count  words written so far in the current load
//
// Build option: LOADER_CHECKSUM_EN adds the XOR accumulator and CHK state.

module prog_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Memory capacity in words, held at 33 bits so a 32-bit N compares
  // without truncation.
  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] WC_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Where a load goes once the last word (or an empty header) is seen.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           n_q, n_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  logic                  rx_ready_q;
  logic                  imem_we_q;
  logic                  cpu_rst_q;
  logic                  load_done_q;
  logic                  load_err_q;

  logic                  accept;
  logic [31:0]           hdr_n;

  assign accept = rx_valid && rx_ready_q;
  // Header value as it will be once the current byte is shifted in; only
  // meaningful on the 4th header byte.
  assign hdr_n  = {rx_data, n_q[31:8]};

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    n_d          = n_q;
    word_d       = word_q;
    word_count_d = word_count_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_HDR;
          byte_cnt_d   = 2'd0;
          word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d        = 8'd0;
`endif
        end
      end

      S_HDR: begin
        if (accept) begin
          n_d        = hdr_n;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            if ({1'b0, hdr_n} > CAP)
              state_d = S_ERR;
            else if (hdr_n == 32'd0)
              state_d = S_END;
            else
              state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          // Bytes enter at the top so byte k ends up at [8k+7:8k].
          word_d     = {rx_data, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3)
            state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        word_count_d = word_count_q + WC_ONE;
        if (32'(word_count_q) + 32'd1 == n_q)
          state_d = S_END;
        else
          state_d = S_DATA;
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept)
          state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Output flags are registered from the next state so they line up with the
  // state they describe and never see inputs combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      n_q          <= 32'd0;
      word_q       <= 32'd0;
      word_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= 8'd0;
`endif
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      n_q          <= n_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
      rx_ready_q   <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
`else
      rx_ready_q   <= (state_d == S_HDR) || (state_d == S_DATA);
`endif
      imem_we_q    <= (state_d == S_WRITE);
      cpu_rst_q    <= (state_d != S_DONE);
      load_done_q  <= (state_d == S_DONE);
      load_err_q   <= (state_d == S_ERR);
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  // word_count still holds the pre-increment value during WRITE.
  assign imem_addr  = word_count_q[ADDR_WIDTH-1:0];
  assign imem_wdata = word_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] tb_xor;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            wr_cyc[$];
  logic          wr_rdy[$];
  logic          wr_crst[$];

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .load_done(load_done),
    .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
      wr_rdy.push_back(rx_ready);
      wr_crst.push_back(cpu_rst);
    end
  end

  task automatic clear_writes();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); wr_rdy.delete(); wr_crst.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tb_xor = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1 within 20 cycles", rx_ready);
    end else begin
      tick();
      tb_xor = tb_xor ^ b;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_word_stall(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      if (k < 3) begin rx_valid = 1'b0; tick(); end
    end
  endtask

  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    send_byte(tb_xor);
`else
    tick();
`endif
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, imem_we, cpu_rst, load_done, load_err} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_flags: {rdy,we,cpu_rst,done,err}=%b required 00100",
               {rx_ready, imem_we, cpu_rst, load_done, load_err});
    end
    checks++;
    if (imem_addr !== '0 || imem_wdata !== 32'h0 || word_count !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%0h wdata=%0h wc=%0d required 0 0 0", imem_addr, imem_wdata, word_count);
    end
    @(negedge clk) rst = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h5A;
    repeat (3) tick();
    checks++;
    if (rx_ready !== 1'b0 || cpu_rst !== 1'b1 || word_count !== '0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: rdy=%b cpu_rst=%b wc=%0d we=%b required 0 1 0 0", rx_ready, cpu_rst, word_count, imem_we);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_two_word();
    clear_writes();
    pulse_start();
    checks++;
    if (rx_ready !== 1'b1) begin errors++; $display("FAIL hdr_ready: rx_ready=%b required 1", rx_ready); end
    send_word(32'd2);
    send_word(32'h00A00513);
    send_word(32'h00500593);
    checks++;
    if (imem_we !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL last_write: we=%b cpu_rst=%b done=%b required 1 1 0", imem_we, cpu_rst, load_done);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h72);
    rx_valid = 1'b0;
`else
    rx_valid = 1'b0;
    tick();
`endif
    checks++;
    if (load_done !== 1'b1 || cpu_rst !== 1'b0 || load_err !== 1'b0 || word_count !== 5'd2) begin
      errors++;
      $display("FAIL two_done: done=%b cpu_rst=%b err=%b wc=%0d required 1 0 0 2", load_done, cpu_rst, load_err, word_count);
    end
    checks++;
    if (wr_addr.size() != 2) begin
      errors++;
      $display("FAIL two_count: writes=%0d required 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'h00A00513) begin
        errors++; $display("FAIL two_w0: addr=%0h data=%h required 0 00a00513", wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_addr[1] !== 4'd1 || wr_data[1] !== 32'h00500593) begin
        errors++; $display("FAIL two_w1: addr=%0h data=%h required 1 00500593", wr_addr[1], wr_data[1]);
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] != 5) begin
        errors++; $display("FAIL two_spacing: cycles=%0d required 5", wr_cyc[1] - wr_cyc[0]);
      end
      checks++;
      if (wr_rdy[0] !== 1'b0 || wr_rdy[1] !== 1'b0 || wr_crst[0] !== 1'b1 || wr_crst[1] !== 1'b1) begin
        errors++; $display("FAIL two_write_flags: rdy=%b%b cpu_rst=%b%b required 00 11", wr_rdy[0], wr_rdy[1], wr_crst[0], wr_crst[1]);
      end
    end
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) tick();
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0 || load_done !== 1'b1 || word_count !== 5'd2 || wr_addr.size() != 2) begin
      errors++;
      $display("FAIL done_ignore: rdy=%b done=%b wc=%0d writes=%0d required 0 1 2 2", rx_ready, load_done, word_count, wr_addr.size());
    end
  endtask

  task automatic test_oversize();
    clear_writes();
    pulse_start();
    checks++;
    if (cpu_rst !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL restart_rst: cpu_rst=%b done=%b required 1 0", cpu_rst, load_done);
    end
    send_word(32'd17);
    rx_valid = 1'b0;
    checks++;
    if (load_err !== 1'b1 || cpu_rst !== 1'b1 || rx_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++; $display("FAIL over_err: err=%b cpu_rst=%b rdy=%b done=%b required 1 1 0 0", load_err, cpu_rst, rx_ready, load_done);
    end
    repeat (2) tick();
    checks++;
    if (load_err !== 1'b1 || wr_addr.size() != 0) begin
      errors++; $display("FAIL over_sticky: err=%b writes=%0d required 1 0", load_err, wr_addr.size());
    end
    pulse_start();
    checks++;
    if (load_err !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL err_clear: err=%b rdy=%b required 0 1", load_err, rx_ready);
    end
    send_word(32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    rx_valid = 1'b0;
    checks++;
    if (load_done !== 1'b1 || cpu_rst !== 1'b0 || word_count !== '0 || wr_addr.size() != 0) begin
      errors++; $display("FAIL empty_image: done=%b cpu_rst=%b wc=%0d writes=%0d required 1 0 0 0", load_done, cpu_rst, word_count, wr_addr.size());
    end
  endtask

  task automatic test_full();
    int bad;
    clear_writes();
    pulse_start();
    send_word(32'd16);
    for (int i = 0; i < 16; i++) send_word(32'hA5000000 | (i * 32'h00010203));
    finish_load();
    checks++;
    if (load_done !== 1'b1 || word_count !== 5'd16 || load_err !== 1'b0) begin
      errors++; $display("FAIL full_done: done=%b wc=%0d err=%b required 1 16 0", load_done, word_count, load_err);
    end
    checks++;
    if (wr_addr.size() != 16) begin
      errors++; $display("FAIL full_count: writes=%0d required 16", wr_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        if (wr_addr[i] !== i[AW-1:0] || wr_data[i] !== (32'hA5000000 | (i * 32'h00010203))) begin
          bad++;
          $display("FAIL full_w%0d: addr=%0h data=%h required %0h %h", i, wr_addr[i], wr_data[i], i, 32'hA5000000 | (i * 32'h00010203));
        end
      end
      checks++;
      if (bad != 0) errors++;
    end
  endtask

  task automatic test_stall_start();
    clear_writes();
    rx_data = 8'h02; rx_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; tb_xor = 8'h00;
    checks++;
    if (word_count !== '0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL start_wins: wc=%0d rdy=%b required 0 1", word_count, rx_ready);
    end
    send_word_stall(32'd2);
    send_byte(8'hEF); rx_valid = 1'b0; tick();
    send_byte(8'hBE); rx_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    send_byte(8'hAD); rx_valid = 1'b0; tick();
    send_byte(8'hDE);
    send_word_stall(32'h01234567);
    finish_load();
    checks++;
    if (load_done !== 1'b1 || word_count !== 5'd2 || load_err !== 1'b0) begin
      errors++; $display("FAIL stall_done: done=%b wc=%0d err=%b required 1 2 0", load_done, word_count, load_err);
    end
    checks++;
    if (wr_addr.size() != 2) begin
      errors++; $display("FAIL stall_count: writes=%0d required 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'hDEADBEEF || wr_addr[1] !== 4'd1 || wr_data[1] !== 32'h01234567) begin
        errors++; $display("FAIL stall_words: %0h:%h %0h:%h required 0:deadbeef 1:01234567", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_writes();
    pulse_start();
    send_word(32'd1); send_word(32'h00000013); send_byte(8'h12);
    rx_valid = 1'b0;
    checks++;
    if (load_done !== 1'b1 || cpu_rst !== 1'b0 || wr_addr.size() != 1) begin
      errors++; $display("FAIL chk_good: done=%b cpu_rst=%b writes=%0d required 1 0 1", load_done, cpu_rst, wr_addr.size());
    end
    pulse_start();
    send_word(32'd1); send_word(32'h00000013); send_byte(8'h00);
    rx_valid = 1'b0;
    checks++;
    if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin
      errors++; $display("FAIL chk_bad: err=%b cpu_rst=%b done=%b required 1 1 0", load_err, cpu_rst, load_done);
    end
  endtask
`endif

  task automatic test_midload_reset();
    clear_writes();
    pulse_start();
    send_word(32'd2);
    send_word(32'h11223344);
    send_byte(8'hAA); send_byte(8'hBB);
    rx_valid = 1'b0;
    checks++;
    if (word_count !== 5'd1) begin
      errors++; $display("FAIL pre_reset_wc: wc=%0d required 1", word_count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rx_ready, imem_we, cpu_rst, load_done, load_err} !== 5'b00100 ||
        word_count !== '0 || imem_addr !== '0 || imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: flags=%b wc=%0d addr=%0h wdata=%h required 00100 0 0 0",
               {rx_ready, imem_we, cpu_rst, load_done, load_err}, word_count, imem_addr, imem_wdata);
    end
    @(negedge clk) rst = 1'b1;
    tick();
    clear_writes();
    pulse_start();
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    finish_load();
    checks++;
    if (load_done !== 1'b1 || word_count !== 5'd1 || wr_addr.size() != 1) begin
      errors++; $display("FAIL reload_done: done=%b wc=%0d writes=%0d required 1 1 1", load_done, word_count, wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'hCAFEF00D) begin
        errors++; $display("FAIL reload_word: addr=%0h data=%h required 0 cafef00d", wr_addr[0], wr_data[0]);
      end
    end
  endtask

  initial begin
    tb_xor = 8'h00;
    test_reset();
    test_two_word();
    test_oversize();
    test_full();
    test_stall_start();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_midload_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

- Boot-time program loader that sits directly upstream of the 5-stage pipelined CPU.
- Accepts a little-endian byte stream from a host link (UART receiver or JTAG bridge), assembles 32-bit instruction words and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset until the whole image has been written, then releases it so fetch starts at PC 0 with a complete program.

## Interface

- ADDR_WIDTH, 10, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- clk  input  1  single clock domain, shared with the CPU's input clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at a rising clk edge.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address of the current write.
- imem_wdata  output  32  assembled instruction word.
- cpu_rst  output  1  active-high reset to the CPU; high in every state except DONE.
- load_done  output  1  image fully written, CPU running.
- load_err  output  1  sticky error flag; cleared only by start or rst.
- word_count  output  ADDR_WIDTH+1  number of words written so far in the current load.

## Operation

- **Image format:** 4-byte header N (word count, LSB first), then N words of 4 bytes each, LSB first. With LOADER_CHECKSUM_EN defined, one trailing checksum byte follows.
- **FSM states:** IDLE, HDR, DATA, WRITE, CHK, DONE, ERR.
- **IDLE:** entered from reset. rx_ready=0. start -> HDR; clears word_count, the byte counter, load_err and the checksum.
- **HDR:** rx_ready=1. Collects 4 bytes into N. After the 4th byte:
  - N > 2^ADDR_WIDTH -> ERR.
  - N == 0 -> CHK if LOADER_CHECKSUM_EN is defined, else DONE.
  - otherwise -> DATA.
- **DATA:** rx_ready=1. Shifts bytes into the word so that byte k of the word lands at bits [8k+7:8k]. After the 4th byte -> WRITE.
- **WRITE:** rx_ready=0. imem_we=1, imem_addr=word_count[ADDR_WIDTH-1:0], imem_wdata=assembled word. word_count increments at the end of the cycle. Next state:
  - word_count+1 == N -> CHK (LOADER_CHECKSUM_EN defined) or DONE.
  - otherwise -> DATA.
- **DONE:** cpu_rst=0, load_done=1, rx_ready=0. Incoming bytes are ignored. start -> HDR, which reasserts cpu_rst.
- **ERR:** cpu_rst=1, load_err=1, rx_ready=0. start -> HDR.
- start arriving in HDR, DATA, WRITE or CHK is ignored.
- start and rx_valid together in IDLE, DONE or ERR: start wins; the byte is not consumed because rx_ready=0 that cycle.
- An asynchronous rst assertion during any state forces all outputs to their reset values immediately. The partial image is abandoned, and memory already written is left as is.

## Timing

- **Reset values:** rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, load_err=0, word_count=0, state IDLE.
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- **Throughput:** rx_ready drops for exactly one cycle per word (the WRITE cycle). Back-to-back valid bytes therefore give 5 cycles per word.
- **Write latency:** imem_we is high in the cycle after the clock edge that accepts the 4th byte of a word.
- **Release latency:** cpu_rst falls, and load_done rises, at the same edge that enters DONE. That edge is the one after the final WRITE cycle, or the one after the checksum byte is accepted.
- rx_valid may stall for any number of cycles in HDR, DATA or CHK; state is held.
- **Width rules:** N is 32-bit, compared against 2^ADDR_WIDTH without truncation. word_count is wide enough to reach 2^ADDR_WIDTH, so a full-memory load is legal. imem_addr never wraps within a load.

## Configuration

- **LOADER_CHECKSUM_EN defined:**
  - XOR of all header and data bytes is accumulated.
  - CHK state: rx_ready=1 and one byte is accepted. Equal to the accumulated XOR -> DONE; otherwise -> ERR.
- **LOADER_CHECKSUM_EN not defined:**
  - The CHK state and the XOR register are absent.
  - The last WRITE (or HDR with N=0) goes straight to DONE, and no trailing byte is consumed.

## Test plan

- **Reset:** rst low, then released -> all outputs at their reset values, cpu_rst=1, rx_ready=0 until start.
- **Two-word load:** start, then bytes 02 00 00 00, 13 05 A0 00, 93 05 50 00 with rx_valid held high -> two writes:
  - imem_addr=0, imem_wdata=0x00A00513;
  - imem_addr=1, imem_wdata=0x00500593, five cycles later;
  - then cpu_rst=0, load_done=1, word_count=2.
- **Oversize header:** ADDR_WIDTH=4, header N=17 -> ERR after the 4th byte, load_err=1, cpu_rst=1, no imem_we. A subsequent start clears load_err.
- **Stall and ignored start:** rx_valid toggled every other cycle mid-word, plus a start pulse during DATA -> same words written, start ignored, no byte lost or duplicated.
- **Checksum (LOADER_CHECKSUM_EN):** N=1, word 0x00000013, checksum 0x12 -> DONE. The same image with checksum 0x00 -> ERR and cpu_rst stays 1.
- **Mid-load reset:** rst pulsed low after 2 data bytes -> immediate return to reset values. A fresh start then loads correctly from address 0.
